// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ synchronous read ports, NUM_WRITE write ports.
// Define REGFILE_MP_FWD_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int ZERO_REG   = 1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_READ-1:0][AW-1:0]          readAddr,
    input  logic [NUM_READ-1:0]                  readEn,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  readData,
    input  logic [NUM_WRITE-1:0][AW-1:0]         writeAddr,
    input  logic [NUM_WRITE-1:0]                 writeEn,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] writeData
);

    logic [DATA_WIDTH-1:0]                regs [NUM_REGS];
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_val;
    logic [NUM_WRITE-1:0]                 wr_ok;

    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            wr_ok[w] = writeEn[w] && !(ZERO_REG != 0 && writeAddr[w] == '0);
        end
    end

    // Later write ports override earlier ones, so port 1 wins an address clash
    // both in the forwarding path and in the array update below.
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd_val[p] = regs[readAddr[p]];
`ifdef REGFILE_MP_FWD_EN
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (writeEn[w] && writeAddr[w] == readAddr[p]) begin
                    rd_val[p] = writeData[w];
                end
            end
`endif
            if (ZERO_REG != 0 && readAddr[p] == '0) begin
                rd_val[p] = '0;
            end
        end
    end

    // readEn is a per-port load strobe for readData: no valid/ready pairing and
    // no backpressure; data appears the cycle after the strobe is sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            readData <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_ok[w]) begin
                    regs[writeAddr[w]] <= writeData[w];
                end
            end
            for (int p = 0; p < NUM_READ; p++) begin
                if (readEn[p]) begin
                    readData[p] <= rd_val[p];
                end
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bit width of every register and data port.
REQ-002 Parameter NUM_REGS, default 32: register count; power of two, >= 2; address width AW = $clog2(NUM_REGS).
REQ-003 Parameter NUM_READ, default 2: number of independent read ports, 1..4.
REQ-004 Parameter NUM_WRITE, default 2: number of independent write ports, 1..2.
REQ-005 Parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero; 0 = register 0 writable.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 readAddr  input  NUM_READ x AW  per-port read address.
REQ-009 readEn  input  NUM_READ  per-port read enable.
REQ-010 readData  output  NUM_READ x DATA_WIDTH  per-port registered read data.
REQ-011 writeAddr  input  NUM_WRITE x AW  per-port write address.
REQ-012 writeEn  input  NUM_WRITE  per-port write enable.
REQ-013 writeData  input  NUM_WRITE x DATA_WIDTH  per-port write data.

Function
REQ-014 Reads SHALL be synchronous: readData[p] updates at the edge where readEn[p]=1 is sampled, visible one cycle after the address is presented.
REQ-015 When readEn[p]=0, readData[p] SHALL hold its previous value.
REQ-016 A write SHALL commit at the rising edge where writeEn[w]=1, becoming readable from the next cycle.
REQ-017 When ZERO_REG=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 on all ports, including under forwarding.
REQ-018 When two write ports target the same address in one cycle, port 1 SHALL win; port 0's data SHALL be discarded.
REQ-019 Writes to distinct addresses in one cycle SHALL both commit.
REQ-020 All read ports SHALL operate independently; multiple ports reading the same address SHALL return identical data.
REQ-021 Register contents SHALL change only via a write or reset.

Reset
REQ-022 When rst_n=0 at a rising edge, all NUM_REGS registers SHALL clear to 0.
REQ-023 When rst_n=0 at a rising edge, all readData ports SHALL clear to 0.
REQ-024 While rst_n=0, writes and reads SHALL be ignored, regardless of writeEn or readEn.
REQ-025 Reset asserted mid-stream SHALL drop any write sampled in that cycle.
REQ-026 The first write SHALL be accepted at the first edge with rst_n=1.

Configuration
REQ-027 Macro REGFILE_MP_FWD_EN defined: a read and an enabled write to the same nonzero-effective address in one cycle SHALL return the new write data in readData the next cycle, after applying the REQ-018 winner rule.
REQ-028 Macro REGFILE_MP_FWD_EN undefined: the same case SHALL return the pre-write (old) register value; the new value SHALL be visible on the following read.

Verification
REQ-029 Reset: write 0xDEADBEEF to r5, assert rst_n=0 one cycle, read r5 -> readData[0]=0; both readData ports read 0 while in reset.
REQ-030 Basic read and write: write 0x12345678 to r7 on port 0, read r7 on ports 0 and 1 next cycle -> both return 0x12345678 one cycle later.
REQ-031 Zero register: with ZERO_REG=1, write 0xFFFFFFFF to r0 -> read r0 returns 0; with ZERO_REG=0 -> returns 0xFFFFFFFF.
REQ-032 Write conflict: port 0 writes 0xAAAA0000 and port 1 writes 0x5555FFFF to r3 in one cycle -> read r3 returns 0x5555FFFF.
REQ-033 Forwarding: r9=0x1 stored, same cycle write r9=0x2 and read r9 -> returns 0x2 with REGFILE_MP_FWD_EN, 0x1 without; next read returns 0x2 in both builds.
REQ-034 Read hold: read r4=0x44, then readEn=0 while r4 is rewritten to 0x99 -> readData holds 0x44 until readEn is reasserted.
